// File: rtl/hazard_if.sv
// Hazard-controller bundle: decode fields, E/M status in, forward/stall/flush out.
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_if #(
    parameter int REG_FILE_ADDRESS_WIDTH = 5
`ifdef HAZARD_PERF_EN
    , parameter int PERF_WIDTH = 32
`endif
);
    logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] RdD;
    logic                              RegWriteD;
    logic [1:0]                        ResultSrcD;
    logic                              PCSrcE;
    logic                              MemReadyM;
    logic [1:0]                        ForwardAE;
    logic [1:0]                        ForwardBE;
    logic                              StallF;
    logic                              StallD;
    logic                              FlushD;
    logic                              FlushE;
    logic                              FreezeAll;
`ifdef HAZARD_PERF_EN
    logic [PERF_WIDTH-1:0]             StallCount;
    logic [PERF_WIDTH-1:0]             FlushCount;
`endif

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeAll
`ifdef HAZARD_PERF_EN
        , input StallCount, FlushCount
`endif
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeAll
`ifdef HAZARD_PERF_EN
        , output StallCount, FlushCount
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and redirect flush control for the 5-stage pipeline.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
    parameter int REG_FILE_ADDRESS_WIDTH = 5
`ifdef HAZARD_PERF_EN
    , parameter int PERF_WIDTH = 32
`endif
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    localparam int AW = REG_FILE_ADDRESS_WIDTH;
    localparam logic [AW-1:0] REG_X0   = {AW{1'b0}};
    localparam logic [1:0]    SRC_LOAD = 2'b01;
    localparam logic [1:0]    FWD_RF   = 2'b00;
    localparam logic [1:0]    FWD_M    = 2'b10;
    localparam logic [1:0]    FWD_W    = 2'b01;

    // Shadow copies of the E, M and W pipeline slots
    logic [AW-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
    logic          reg_write_e_q, reg_write_e_d, is_load_e_q, is_load_e_d;
    logic [AW-1:0] rd_m_q, rd_m_d;
    logic          reg_write_m_q, reg_write_m_d, is_load_m_q, is_load_m_d;
    logic [AW-1:0] rd_w_q, rd_w_d;
    logic          reg_write_w_q, reg_write_w_d;

    logic freeze_s, redirect_s, lw_stall_s, stall_s, flush_e_s;

    // Loads in M are excluded so a load value is only ever taken from W.
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rd_m, input logic wr_m, input logic ld_m,
        input logic [AW-1:0] rd_w, input logic wr_w
    );
        logic [1:0] sel;
        if (wr_m && !ld_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard detection and control outputs
    always_comb begin
        freeze_s   = ~hz.MemReadyM;
        redirect_s = hz.PCSrcE;
        lw_stall_s = is_load_e_q & reg_write_e_q & (rd_e_q != REG_X0) &
                     ((rd_e_q == hz.Rs1D) | (rd_e_q == hz.Rs2D));
        stall_s    = freeze_s | (lw_stall_s & ~redirect_s);
        flush_e_s  = (lw_stall_s | redirect_s) & ~freeze_s;
    end

    assign hz.FreezeAll = freeze_s;
    assign hz.StallF    = stall_s;
    assign hz.StallD    = stall_s;
    assign hz.FlushD    = redirect_s & ~freeze_s;
    assign hz.FlushE    = flush_e_s;
    assign hz.ForwardAE = fwd_select(rs1_e_q, rd_m_q, reg_write_m_q, is_load_m_q,
                                     rd_w_q, reg_write_w_q);
    assign hz.ForwardBE = fwd_select(rs2_e_q, rd_m_q, reg_write_m_q, is_load_m_q,
                                     rd_w_q, reg_write_w_q);

    // Next-state of the shadow slots: hold on freeze, otherwise advance
    always_comb begin
        rs1_e_d       = rs1_e_q;
        rs2_e_d       = rs2_e_q;
        rd_e_d        = rd_e_q;
        reg_write_e_d = reg_write_e_q;
        is_load_e_d   = is_load_e_q;
        rd_m_d        = rd_m_q;
        reg_write_m_d = reg_write_m_q;
        is_load_m_d   = is_load_m_q;
        rd_w_d        = rd_w_q;
        reg_write_w_d = reg_write_w_q;
        if (freeze_s) begin
            rd_w_d = rd_w_q;
        end else begin
            rd_w_d        = rd_m_q;
            reg_write_w_d = reg_write_m_q;
            rd_m_d        = rd_e_q;
            reg_write_m_d = reg_write_e_q;
            is_load_m_d   = is_load_e_q;
            if (flush_e_s) begin
                rs1_e_d       = REG_X0;
                rs2_e_d       = REG_X0;
                rd_e_d        = REG_X0;
                reg_write_e_d = 1'b0;
                is_load_e_d   = 1'b0;
            end else begin
                rs1_e_d       = hz.Rs1D;
                rs2_e_d       = hz.Rs2D;
                rd_e_d        = hz.RdD;
                reg_write_e_d = hz.RegWriteD;
                is_load_e_d   = (hz.ResultSrcD == SRC_LOAD);
            end
        end
    end

    // Shadow slot registers; reset loads bubbles everywhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e_q       <= REG_X0;
            rs2_e_q       <= REG_X0;
            rd_e_q        <= REG_X0;
            reg_write_e_q <= 1'b0;
            is_load_e_q   <= 1'b0;
            rd_m_q        <= REG_X0;
            reg_write_m_q <= 1'b0;
            is_load_m_q   <= 1'b0;
            rd_w_q        <= REG_X0;
            reg_write_w_q <= 1'b0;
        end else begin
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            reg_write_e_q <= reg_write_e_d;
            is_load_e_q   <= is_load_e_d;
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            is_load_m_q   <= is_load_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_WIDTH-1:0] PERF_ONE = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

    logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

    // Counter increments; frozen cycles are not counted as stalls
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_s & ~freeze_s) begin
            stall_count_d = stall_count_q + PERF_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (flush_e_s) begin
            flush_count_d = flush_count_q + PERF_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= {PERF_WIDTH{1'b0}};
            flush_count_q <= {PERF_WIDTH{1'b0}};
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hz.StallCount = stall_count_q;
    assign hz.FlushCount = flush_count_q;
`endif
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core; it produces the `ForwardAE`/`ForwardBE` selects consumed by the execute stage, plus the stall and flush controls for the fetch, decode and execute pipeline registers. The block keeps registered shadow copies of the destination, write-enable and load information for the E, M and W stages. These shadows advance in lockstep with the real pipeline, so forwarding and load-use detection come only from the block's own state and the decode-stage fields. A data-memory not-ready signal freezes the whole pipeline and the shadows with it.

## Interface
- `REG_FILE_ADDRESS_WIDTH`, default 5: register index width.
- `PERF_WIDTH`, default 32: width of the performance counters (only with `HAZARD_PERF_EN`).

- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Rs1D`, `Rs2D` input REG_FILE_ADDRESS_WIDTH: decode-stage source registers.
- `RdD` input REG_FILE_ADDRESS_WIDTH: decode-stage destination.
- `RegWriteD` input 1: decode instruction writes the register file.
- `ResultSrcD` input 2: decode result source; `2'b01` means load.
- `PCSrcE` input 1: taken branch or jump resolved in E.
- `MemReadyM` input 1: data memory ready; 0 freezes the pipeline.
- `ForwardAE`, `ForwardBE` output 2: `00` register file, `10` M-stage ALU result, `01` W-stage result.
- `StallF`, `StallD` output 1: hold the PC and the IF/ID register.
- `FlushD`, `FlushE` output 1: bubble the IF/ID and ID/EX registers.
- `FreezeAll` output 1: hold the ID/EX, EX/MEM and MEM/WB registers.
- `StallCount`, `FlushCount` output PERF_WIDTH: performance counters (only with `HAZARD_PERF_EN`).

## Operation
- Shadow slots E, M and W each hold: `Rd`, `RegWrite`, `IsLoad`. Slot E also holds `Rs1` and `Rs2`.
- Definitions:
  - `freeze = ~MemReadyM`
  - `lwStall = IsLoadE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)`
  - `redirect = PCSrcE`
- Control outputs (combinational from shadows and inputs):
  - `FreezeAll = freeze`
  - `StallF = StallD = freeze | (lwStall & ~redirect)`
  - `FlushD = redirect & ~freeze`
  - `FlushE = (lwStall | redirect) & ~freeze`
- Redirect takes priority over load-use: the decode instruction is discarded, so no stall is raised.
- ForwardAE selection, by priority:
  1. `10` if `RegWriteM & RdM != 0 & RdM == Rs1E`.
  2. Otherwise `01` if `RegWriteW & RdW != 0 & RdW == Rs1E`.
  3. Otherwise `00`.
- ForwardBE follows the same rules using `Rs2E`.
- Register x0 is never forwarded and never causes a stall.
- Shadow update on each clock edge:
  - If `freeze`: all slots hold.
  - Otherwise: W ← M and M ← E.
  - E ← bubble (`RegWrite=0`, `Rd=0`, `IsLoad=0`, `Rs=0`) if `FlushE`.
  - Otherwise E ← {`Rs1D`, `Rs2D`, `RdD`, `RegWriteD`, `ResultSrcD==2'b01`}.
- A load in M is never forwarded from M. The load-use bubble guarantees the consumer reaches E only when the load is in W.

## Timing
- Reset clears every shadow slot to the bubble value.
- Outputs during and immediately after reset:
  - `ForwardAE = ForwardBE = 00`.
  - `FlushD`, `FlushE`, `StallF`, `StallD` are 0 unless `PCSrcE` is high.
  - `FreezeAll` follows `~MemReadyM`.
  - Counters are 0.
- Forward selects are valid in the same cycle the consumer occupies E (zero latency from shadow state).
- Load-use costs exactly one bubble:
  - Cycle n: load in E, consumer in D; `StallF`/`StallD`/`FlushE` are 1.
  - Cycle n+1: load in M, bubble in E.
  - Cycle n+2: consumer in E with `ForwardxE=01`.
- Freeze can last any length. Outputs stay constant while frozen, apart from the combinational dependence on `PCSrcE` and the D fields. Flushes are suppressed during freeze and take effect on the first ready cycle.
- Reset asserted mid-stall or mid-freeze: shadows are bubbled immediately; no pending stall survives.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `StallCount` increments on each cycle where `StallD & ~freeze`.
  - `FlushCount` increments on each cycle where `FlushE`.
  - Both wrap modulo 2^PERF_WIDTH and reset to 0.
- `HAZARD_PERF_EN` undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- ALU dependency on the previous instruction: `add x5,x1,x2` then `sub x6,x5,x3` → `ForwardAE=10` in the sub's E cycle; no stall.
- Dependency two instructions back: `add x5`; `nop`; `or x7,x4,x5` → `ForwardBE=01`.
- Load-use: `lw x8,0(x1)`; `add x9,x8,x8` → one cycle of `StallF=StallD=FlushE=1`, then `ForwardAE=ForwardBE=01`.
- Load-use coinciding with `PCSrcE=1` → `FlushD=FlushE=1` and `StallD=0`.
- x0 and write-disabled producers:
  - Write to x0 followed by a reader of x0 → `ForwardAE=00`.
  - `RegWriteM=0` with a matching `RdM` → `00`.
- `MemReadyM=0` for 3 cycles during a load-use bubble:
  - `FreezeAll=1`, shadows held, no flush.
  - Behaviour resumes correctly once ready.
  - With `HAZARD_PERF_EN`, `StallCount` does not increase while frozen.
